// File: rtl/idma_eh_arbiter.sv
//------------------------------------------------------------------------------
// idma_eh_arbiter: round-robin merge of per-channel iDMA error-handler responses
// with a single outstanding error and decision routing back to the channel.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package idma_pkg;
   typedef struct packed {
      logic        error;
      logic        last;
      logic [31:0] pld;
   } idma_rsp_t;

   typedef logic idma_eh_req_t;

   localparam idma_eh_req_t CONTINUE = 1'b0;
   localparam idma_eh_req_t ABORT    = 1'b1;
endpackage

module idma_eh_arbiter #(
   parameter int unsigned NumChannels   = 4,
   parameter int unsigned TimeoutCycles = 0,
   parameter type         idma_rsp_t    = idma_pkg::idma_rsp_t,
   parameter type         idma_eh_req_t = idma_pkg::idma_eh_req_t,
   localparam int unsigned CW           = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  idma_rsp_t    [NumChannels-1:0]   ch_rsp_i,
   input  logic         [NumChannels-1:0]   ch_rsp_valid_i,
   output logic         [NumChannels-1:0]   ch_rsp_ready_o,
   output idma_eh_req_t [NumChannels-1:0]   ch_eh_o,
   output logic         [NumChannels-1:0]   ch_eh_valid_o,
   input  logic         [NumChannels-1:0]   ch_eh_ready_i,
   output idma_rsp_t                        rsp_o,
   output logic         [CW-1:0]            rsp_chan_o,
   output logic                             rsp_valid_o,
   input  logic                             rsp_ready_i,
   input  idma_eh_req_t                     eh_i,
   input  logic                             eh_valid_i,
   output logic                             eh_ready_o,
   output logic                             timeout_o,
   output logic                             busy_o
);

   localparam int unsigned   TW       = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
   localparam logic [TW-1:0] TMO_LAST = (TimeoutCycles > 0) ? TW'(TimeoutCycles - 1) : '0;
   localparam logic [TW-1:0] TMO_MAX  = '1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ERR_WAIT = 2'd1,
      ERR_FWD  = 2'd2
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_lock;
   idma_eh_req_t    r_dec;
   logic [CW-1:0]   r_rr;
   logic [TW-1:0]   r_tmo;
   logic            r_hold;
   logic [CW-1:0]   r_hold_ch;

   logic [NumChannels-1:0] w_elig;
   logic [CW-1:0]          w_gnt;
   logic                   w_gnt_vld;
   logic                   w_hs;
   logic                   w_tmo_hit;

   // Modular channel index that stays correct for non-power-of-2 channel counts.
   function automatic logic [CW-1:0] f_wrap(input logic [CW-1:0] base, input int unsigned ofs);
      int unsigned s;
      s = 32'(base) + ofs;
      if (s >= NumChannels) s = s - NumChannels;
      return CW'(s);
   endfunction

   always_comb begin
      for (int i = 0; i < NumChannels; i++) begin
         w_elig[i] = ch_rsp_valid_i[i];
         if (r_state != IDLE && (r_lock == CW'(i) || ch_rsp_i[i].error)) w_elig[i] = 1'b0;
      end
   end

   // A stalled grant is pinned so the presented response cannot change under the consumer.
   always_comb begin
      w_gnt     = '0;
      w_gnt_vld = 1'b0;
      if (r_hold) begin
         w_gnt     = r_hold_ch;
         w_gnt_vld = ch_rsp_valid_i[r_hold_ch];
      end else begin
         for (int unsigned k = 0; k < NumChannels; k++) begin
            if (!w_gnt_vld && w_elig[f_wrap(r_rr, k)]) begin
               w_gnt_vld = 1'b1;
               w_gnt     = f_wrap(r_rr, k);
            end
         end
      end
   end

   assign w_hs        = w_gnt_vld && rsp_ready_i;
   assign rsp_valid_o = w_gnt_vld;
   assign rsp_o       = w_gnt_vld ? ch_rsp_i[w_gnt] : '0;
   assign rsp_chan_o  = w_gnt_vld ? w_gnt : '0;

   always_comb begin
      for (int i = 0; i < NumChannels; i++) begin
         ch_rsp_ready_o[i] = w_hs && (w_gnt == CW'(i));
         ch_eh_valid_o[i]  = (r_state == ERR_FWD) && (r_lock == CW'(i));
         ch_eh_o[i]        = ch_eh_valid_o[i] ? r_dec : '0;
      end
   end

   assign w_tmo_hit  = (TimeoutCycles != 0) && (r_state == ERR_WAIT) && !eh_valid_i
                       && (r_tmo == TMO_LAST);
   assign timeout_o  = w_tmo_hit;
   assign eh_ready_o = (r_state == ERR_WAIT);
   assign busy_o     = (r_state != IDLE);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= IDLE;
         r_lock    <= '0;
         r_dec     <= '0;
         r_rr      <= '0;
         r_tmo     <= '0;
         r_hold    <= 1'b0;
         r_hold_ch <= '0;
      end else begin
         if (w_hs) r_rr <= f_wrap(w_gnt, 1);
         r_hold <= w_gnt_vld && !rsp_ready_i;
         if (w_gnt_vld && !rsp_ready_i) r_hold_ch <= w_gnt;

         case (r_state)
            IDLE: begin
               if (w_hs && rsp_o.error) begin
                  r_lock  <= w_gnt;
                  r_tmo   <= '0;
                  r_state <= ERR_WAIT;
               end
            end
            ERR_WAIT: begin
               if (eh_valid_i) begin
                  r_dec   <= eh_i;
                  r_state <= ERR_FWD;
               end else if (w_tmo_hit) begin
                  r_dec   <= idma_eh_req_t'(idma_pkg::ABORT);
                  r_state <= ERR_FWD;
               end else if (r_tmo != TMO_MAX) begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            ERR_FWD: begin
               if (ch_eh_ready_i[r_lock]) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_idma_eh_arbiter.sv
//------------------------------------------------------------------------------
// tb_idma_eh_arbiter: directed vector table plus multi-cycle error sequences.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_idma_eh_arbiter;

   logic                              clk_i = 1'b0;
   logic                              rst_i = 1'b1;
   idma_pkg::idma_rsp_t    [3:0]      ch_rsp;
   logic                   [3:0]      v = '0;
   logic                   [3:0]      err = '0;
   logic                   [3:0]      ch_rsp_ready;
   idma_pkg::idma_eh_req_t [3:0]      ch_eh;
   logic                   [3:0]      ch_eh_valid;
   logic                   [3:0]      ch_eh_ready = '0;
   idma_pkg::idma_rsp_t               rsp;
   logic                   [1:0]      rsp_chan;
   logic                              rsp_valid;
   logic                              rsp_ready = 1'b1;
   idma_pkg::idma_eh_req_t            eh = 1'b0;
   logic                              eh_valid = 1'b0;
   logic                              eh_ready;
   logic                              timeout;
   logic                              busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         ch_rsp[i].error = err[i];
         ch_rsp[i].last  = 1'b1;
         ch_rsp[i].pld   = 32'hA0 + 32'(i);
      end
   end

   idma_eh_arbiter #(
      .NumChannels   (4),
      .TimeoutCycles (8)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .ch_rsp_i       (ch_rsp),
      .ch_rsp_valid_i (v),
      .ch_rsp_ready_o (ch_rsp_ready),
      .ch_eh_o        (ch_eh),
      .ch_eh_valid_o  (ch_eh_valid),
      .ch_eh_ready_i  (ch_eh_ready),
      .rsp_o          (rsp),
      .rsp_chan_o     (rsp_chan),
      .rsp_valid_o    (rsp_valid),
      .rsp_ready_i    (rsp_ready),
      .eh_i           (eh),
      .eh_valid_i     (eh_valid),
      .eh_ready_o     (eh_ready),
      .timeout_o      (timeout),
      .busy_o         (busy)
   );

   typedef struct {
      logic [3:0] v;
      logic       rdy;
      logic       exp_vld;
      logic [1:0] exp_ch;
      logic [3:0] exp_crdy;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_grant(input string nm, input logic vld, input logic [1:0] ch,
                            input logic [3:0] crdy);
      idma_pkg::idma_rsp_t e;
      e = '0;
      if (vld) begin
         e.error = err[ch];
         e.last  = 1'b1;
         e.pld   = 32'hA0 + 32'(ch);
      end
      chk({nm, " valid"}, 64'(rsp_valid), 64'(vld));
      chk({nm, " chan"}, 64'(rsp_chan), vld ? 64'(ch) : 64'd0);
      chk({nm, " ch_ready"}, 64'(ch_rsp_ready), 64'(crdy));
      chk({nm, " rsp"}, 64'(rsp), 64'(e));
   endtask

   task automatic resolve(input string nm, input int ch, input logic dec);
      chk({nm, " eh_valid"}, 64'(ch_eh_valid), 64'(4'b0001 << ch));
      chk({nm, " eh_dec"}, 64'(ch_eh[ch]), 64'(dec));
      chk({nm, " busy fwd"}, 64'(busy), 64'd1);
      ch_eh_ready = 4'b0001 << ch;
      tick();
      ch_eh_ready = '0;
      #1;
      chk({nm, " idle"}, 64'(busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int pulses;

      vecs[0]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};
      vecs[1]  = '{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001};
      vecs[2]  = '{4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010};
      vecs[3]  = '{4'b1111, 1'b1, 1'b1, 2'd2, 4'b0100};
      vecs[4]  = '{4'b1111, 1'b1, 1'b1, 2'd3, 4'b1000};
      vecs[5]  = '{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001};
      vecs[6]  = '{4'b0001, 1'b1, 1'b1, 2'd0, 4'b0001};
      vecs[7]  = '{4'b1000, 1'b0, 1'b1, 2'd3, 4'b0000};
      vecs[8]  = '{4'b1010, 1'b1, 1'b1, 2'd3, 4'b1000};
      vecs[9]  = '{4'b0110, 1'b1, 1'b1, 2'd1, 4'b0010};
      vecs[10] = '{4'b0011, 1'b1, 1'b1, 2'd0, 4'b0001};

      // Reset state
      tick();
      tick();
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset eh_ready", 64'(eh_ready), 64'd0);
      chk("reset timeout", 64'(timeout), 64'd0);
      chk("reset ch_eh_valid", 64'(ch_eh_valid), 64'd0);
      chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
      rst_i = 1'b0;
      tick();

      // Table: error-free round-robin, hold and wrap behaviour
      foreach (vecs[i]) begin
         v         = vecs[i].v;
         rsp_ready = vecs[i].rdy;
         #1;
         chk_grant($sformatf("vec%0d", i), vecs[i].exp_vld, vecs[i].exp_ch, vecs[i].exp_crdy);
         chk($sformatf("vec%0d busy", i), 64'(busy), 64'd0);
         tick();
      end
      rsp_ready = 1'b1;

      // ch2 error, ch1 keeps flowing, frontend ABORT, ch0 error stalls
      v = 4'b0100; err = 4'b0100;
      #1;
      chk_grant("err2 accept", 1'b1, 2'd2, 4'b0100);
      tick();
      v = 4'b0010; err = 4'b0000;
      #1;
      chk("err2 busy", 64'(busy), 64'd1);
      chk("err2 eh_ready", 64'(eh_ready), 64'd1);
      chk_grant("err2 ch1 pass a", 1'b1, 2'd1, 4'b0010);
      tick();
      v = 4'b0011; err = 4'b0001;
      #1;
      chk_grant("err2 ch1 pass b", 1'b1, 2'd1, 4'b0010);
      tick();
      v = 4'b0000; err = 4'b0000;
      eh_valid = 1'b1; eh = idma_pkg::ABORT;
      #1;
      chk("err2 ch_eh idle", 64'(ch_eh_valid), 64'd0);
      tick();
      eh_valid = 1'b1; eh = idma_pkg::CONTINUE;
      #1;
      chk("err2 fwd eh_ready", 64'(eh_ready), 64'd0);
      tick();
      eh_valid = 1'b0;
      #1;
      resolve("err2", 2, idma_pkg::ABORT);

      // ch1 error with no decision: auto-abort after 8 cycles
      v = 4'b0010; err = 4'b0010;
      #1;
      chk_grant("tmo accept", 1'b1, 2'd1, 4'b0010);
      tick();
      v = '0; err = '0;
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk($sformatf("tmo wait%0d", k), 64'(eh_ready), 64'd1);
         chk($sformatf("tmo pulse%0d", k), 64'(timeout), (k == 7) ? 64'd1 : 64'd0);
         if (timeout) pulses++;
         tick();
      end
      #1;
      chk("tmo pulse after", 64'(timeout), 64'd0);
      chk("tmo pulse count", 64'(pulses), 64'd1);
      resolve("tmo", 1, idma_pkg::ABORT);

      // Decision arriving on the timeout cycle wins
      v = 4'b0010; err = 4'b0010;
      tick();
      v = '0; err = '0;
      for (int k = 0; k < 8; k++) begin
         if (k == 7) begin
            eh_valid = 1'b1; eh = idma_pkg::CONTINUE;
         end
         #1;
         if (k == 7) chk("tie timeout", 64'(timeout), 64'd0);
         tick();
      end
      eh_valid = 1'b0;
      #1;
      resolve("tie", 1, idma_pkg::CONTINUE);

      // Simultaneous ch0/ch3 errors with rr=3
      v = 4'b0100;
      #1;
      chk_grant("rr3 setup", 1'b1, 2'd2, 4'b0100);
      tick();
      v = 4'b1001; err = 4'b1001;
      #1;
      chk_grant("dual err ch3", 1'b1, 2'd3, 4'b1000);
      tick();
      v = 4'b0001;
      #1;
      chk_grant("dual ch0 stall", 1'b0, 2'd0, 4'b0000);
      eh_valid = 1'b1; eh = idma_pkg::CONTINUE;
      tick();
      eh_valid = 1'b0;
      #1;
      chk_grant("dual ch0 stall fwd", 1'b0, 2'd0, 4'b0000);
      resolve("dual ch3", 3, idma_pkg::CONTINUE);
      chk_grant("dual ch0 accept", 1'b1, 2'd0, 4'b0001);
      tick();
      v = '0; err = '0;
      eh_valid = 1'b1; eh = idma_pkg::ABORT;
      tick();
      eh_valid = 1'b0;
      #1;
      chk("pre-reset eh_valid", 64'(ch_eh_valid), 64'(4'b0001));

      // Asynchronous reset during ERR_FWD
      #2;
      rst_i = 1'b1;
      #1;
      chk("arst busy", 64'(busy), 64'd0);
      chk("arst ch_eh_valid", 64'(ch_eh_valid), 64'd0);
      chk("arst eh_ready", 64'(eh_ready), 64'd0);
      tick();
      rst_i = 1'b0;
      ch_eh_ready = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("post-reset eh_valid%0d", k), 64'(ch_eh_valid), 64'd0);
         chk($sformatf("post-reset busy%0d", k), 64'(busy), 64'd0);
         tick();
      end
      ch_eh_ready = '0;

      // Stalled grant of ch2 holds while higher-priority ch0 rises (rr=0)
      v = 4'b0100; rsp_ready = 1'b0;
      #1;
      chk_grant("hold c0", 1'b1, 2'd2, 4'b0000);
      tick();
      v = 4'b0101;
      for (int k = 1; k < 5; k++) begin
         #1;
         chk_grant($sformatf("hold c%0d", k), 1'b1, 2'd2, 4'b0000);
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      chk_grant("hold release", 1'b1, 2'd2, 4'b0100);
      tick();
      v = 4'b0001;
      #1;
      chk_grant("hold after", 1'b1, 2'd0, 4'b0001);
      tick();
      v = '0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
